// File: rtl/usb_rx_fsm_if.sv
// Link between the bit-level receive front end (NRZI decoder / un-stuffer) and the
// USB receive packet FSM. The front end is the master, the FSM the slave.
interface usb_rx_fsm_if #(
  parameter int CNT_W = 11
) ();
  logic             rx_enable;
  logic             rx_bit;
  logic             rx_bit_valid;
  logic             rx_se0;
  logic             stuff_err;
  logic [7:0]       rx_data;
  logic             rx_valid;
  logic             rx_active;
  logic             rx_done;
  logic             rx_error;
  logic [1:0]       rx_err_code;
  logic [CNT_W-1:0] rx_byte_cnt;

  modport master (
    output rx_enable, rx_bit, rx_bit_valid, rx_se0, stuff_err,
    input  rx_data, rx_valid, rx_active, rx_done, rx_error, rx_err_code, rx_byte_cnt
  );

  modport slave (
    input  rx_enable, rx_bit, rx_bit_valid, rx_se0, stuff_err,
    output rx_data, rx_valid, rx_active, rx_done, rx_error, rx_err_code, rx_byte_cnt
  );
endinterface

// File: rtl/usb_rx_fsm.sv
// USB receive packet FSM: hunts SYNC, assembles LSB-first bytes, detects EOP and
// reports bytes, clean completion and abort reasons. All outputs are registered.
module usb_rx_fsm #(
  parameter logic [7:0] SYNC_BYTE    = 8'h80,
  parameter int         SYNC_TIMEOUT = 32,
  parameter int         MAX_BYTES    = 1026,
  parameter int         CNT_W        = 11
) (
  input logic         clk,
  input logic         nRST,
  usb_rx_fsm_if.slave bus
);

  localparam int TO_W = $clog2(SYNC_TIMEOUT + 1);
  localparam int BC_W = (TO_W > 4) ? TO_W : 4;

  typedef enum logic [2:0] {
    RX_S_IDLE,
    RX_S_SYNC,
    RX_S_DATA,
    RX_S_EOP,
    RX_S_ERR,
    RX_S_DRAIN
  } rx_state_t;

  typedef enum logic [1:0] {
    ERR_SYNC_TO  = 2'b00,
    ERR_STUFF    = 2'b01,
    ERR_PARTIAL  = 2'b10,
    ERR_OVERFLOW = 2'b11
  } err_code_t;

  rx_state_t        state, state_nxt;
  logic [6:0]       sync_sr, sync_sr_nxt;   // upper 7 bits of the SYNC window; bit 0 falls out next shift
  logic [6:0]       data_sr, data_sr_nxt;
  logic [BC_W-1:0]  bit_cnt, bit_cnt_nxt, bit_inc;
  logic [CNT_W-1:0] byte_cnt, byte_cnt_nxt;
  logic [7:0]       rx_data_q, rx_data_nxt;
  logic [7:0]       sync_win, byte_win;
  logic [1:0]       err_code_q, err_code_nxt;
  logic             valid_q, valid_nxt;
  logic             done_q, done_nxt;
  logic             error_q, error_nxt;
  logic             active_q, active_nxt;
  logic             se0_prev;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c >= CNT_W'(MAX_BYTES)) ? c : c + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) state <= RX_S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    sync_sr_nxt  = sync_sr;
    data_sr_nxt  = data_sr;
    bit_cnt_nxt  = bit_cnt;
    byte_cnt_nxt = byte_cnt;
    rx_data_nxt  = rx_data_q;
    err_code_nxt = err_code_q;
    valid_nxt    = 1'b0;
    done_nxt     = 1'b0;
    error_nxt    = 1'b0;
    sync_win     = {bus.rx_bit, sync_sr};
    byte_win     = {bus.rx_bit, data_sr};
    bit_inc      = bit_cnt + BC_W'(1);

    if (!bus.rx_enable) begin
      state_nxt = RX_S_IDLE;
    end else begin
      unique case (state)
        RX_S_IDLE: begin
          if (!bus.rx_se0 && bus.rx_bit_valid) begin
            sync_sr_nxt = sync_win[7:1];
            bit_cnt_nxt = BC_W'(1);
            state_nxt   = RX_S_SYNC;
          end
        end

        RX_S_SYNC: begin
          if (bus.rx_se0) begin
            state_nxt = RX_S_IDLE;
          end else if (bus.rx_bit_valid) begin
            sync_sr_nxt = sync_win[7:1];
            bit_cnt_nxt = bit_inc;
            // A match on the very bit that reaches the timeout still counts as SYNC.
            if (bit_inc >= BC_W'(8) && sync_win == SYNC_BYTE) begin
              state_nxt    = RX_S_DATA;
              bit_cnt_nxt  = '0;
              byte_cnt_nxt = '0;
            end else if (bit_inc >= BC_W'(SYNC_TIMEOUT)) begin
              state_nxt    = RX_S_ERR;
              error_nxt    = 1'b1;
              err_code_nxt = ERR_SYNC_TO;
            end
          end
        end

        RX_S_DATA: begin
          if (bus.stuff_err) begin
            state_nxt    = RX_S_ERR;
            error_nxt    = 1'b1;
            err_code_nxt = ERR_STUFF;
          end else if (bus.rx_se0) begin
            if (bit_cnt == '0) begin
              state_nxt = RX_S_EOP;
            end else begin
              state_nxt    = RX_S_ERR;
              error_nxt    = 1'b1;
              err_code_nxt = ERR_PARTIAL;
            end
          end else if (bus.rx_bit_valid) begin
            if (bit_cnt == BC_W'(7)) begin
              bit_cnt_nxt = '0;
              if (byte_cnt >= CNT_W'(MAX_BYTES)) begin
                state_nxt    = RX_S_ERR;
                error_nxt    = 1'b1;
                err_code_nxt = ERR_OVERFLOW;
              end else begin
                rx_data_nxt  = byte_win;
                valid_nxt    = 1'b1;
                byte_cnt_nxt = sat_inc(byte_cnt);
              end
            end else begin
              data_sr_nxt[bit_cnt[2:0]] = bus.rx_bit;
              bit_cnt_nxt               = bit_inc;
            end
          end
        end

        RX_S_EOP: begin
          if (!bus.rx_se0) begin
            done_nxt  = 1'b1;
            state_nxt = RX_S_IDLE;
          end
        end

        RX_S_ERR: begin
          state_nxt = RX_S_DRAIN;
        end

        RX_S_DRAIN: begin
          if (se0_prev && !bus.rx_se0) state_nxt = RX_S_IDLE;
        end

        default: begin
          state_nxt = RX_S_IDLE;
        end
      endcase
    end

    active_nxt = (state_nxt == RX_S_DATA) || (state_nxt == RX_S_EOP);
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      sync_sr    <= '0;
      data_sr    <= '0;
      bit_cnt    <= '0;
      byte_cnt   <= '0;
      rx_data_q  <= '0;
      err_code_q <= '0;
      valid_q    <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      active_q   <= 1'b0;
      se0_prev   <= 1'b0;
    end else begin
      sync_sr    <= sync_sr_nxt;
      data_sr    <= data_sr_nxt;
      bit_cnt    <= bit_cnt_nxt;
      byte_cnt   <= byte_cnt_nxt;
      rx_data_q  <= rx_data_nxt;
      err_code_q <= err_code_nxt;
      valid_q    <= valid_nxt;
      done_q     <= done_nxt;
      error_q    <= error_nxt;
      active_q   <= active_nxt;
      se0_prev   <= bus.rx_se0;
    end
  end

  assign bus.rx_data     = rx_data_q;
  assign bus.rx_valid    = valid_q;
  assign bus.rx_active   = active_q;
  assign bus.rx_done     = done_q;
  assign bus.rx_error    = error_q;
  assign bus.rx_err_code = err_code_q;
  assign bus.rx_byte_cnt = byte_cnt;

endmodule

// File: tb/tb_usb_rx_fsm.sv
// Bench for usb_rx_fsm: directed packets plus random packets, each scored against a
// packet-level model (find SYNC in the bit stream, slice bytes, classify the ending).
module tb_usb_rx_fsm;
  localparam int MAXB = 4;
  localparam int CW   = 11;
  typedef logic [7:0] byte_t;

  logic clk = 1'b0;
  logic nRST;
  int   cyc = 0;

  usb_rx_fsm_if #(.CNT_W(CW)) bus ();

  usb_rx_fsm #(
    .SYNC_BYTE   (8'h80),
    .SYNC_TIMEOUT(32),
    .MAX_BYTES   (MAXB),
    .CNT_W       (CW)
  ) dut (
    .clk (clk),
    .nRST(nRST),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor, sampled on the falling edge
  byte_t      obs_q[$];
  int         n_done = 0, n_err = 0, done_cyc = 0, err_cyc = 0;
  logic [1:0] err_obs = 2'b00;
  always @(negedge clk) begin
    if (bus.rx_valid) obs_q.push_back(bus.rx_data);
    if (bus.rx_done) begin
      n_done   <= n_done + 1;
      done_cyc <= cyc;
    end
    if (bus.rx_error) begin
      n_err   <= n_err + 1;
      err_obs <= bus.rx_err_code;
      err_cyc <= cyc;
    end
  end

  int    tests = 0, fails = 0;
  bit    st[$];
  int    bit_cyc[$];
  int    stuff_cyc, se0_rise_cyc, se0_fall_cyc;
  byte_t exp_bytes[$];
  byte_t exp_last = 8'h00;
  int    exp_cnt = 0, exp_m, exp_done, exp_err;
  int    exp_code = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input bit b, input int gap);
    bus.rx_bit       = b;
    bus.rx_bit_valid = 1'b1;
    bit_cyc.push_back(cyc);
    tick();
    bus.rx_bit_valid = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic push_sync();
    repeat (7) st.push_back(1'b0);
    st.push_back(1'b1);
  endtask

  task automatic push_byte(input byte_t v);
    for (int j = 0; j < 8; j++) st.push_back(v[j]);
  endtask

  // Packet-level expectation for the bit stream in st; term 1 = stuff error after the last bit
  task automatic model(input int term);
    int n, lim, len, full;
    bit ok;
    byte_t v;
    n = st.size();
    exp_m = -1;
    exp_done = 0;
    exp_err = 0;
    exp_bytes.delete();
    lim = (n < 32) ? n : 32;
    for (int i = 7; i < lim && exp_m < 0; i++) begin
      ok = st[i];
      for (int j = 1; j <= 7; j++) if (st[i-j]) ok = 1'b0;
      if (ok) exp_m = i;
    end
    if (exp_m < 0) begin
      if (n >= 32) begin
        exp_err = 1;
        exp_code = 0;
      end
    end else begin
      len = n - exp_m - 1;
      full = len / 8;
      exp_cnt = 0;
      for (int k = 0; k < full && k < MAXB; k++) begin
        for (int j = 0; j < 8; j++) v[j] = st[exp_m + 1 + 8*k + j];
        exp_bytes.push_back(v);
        exp_last = v;
        exp_cnt = k + 1;
      end
      if (full > MAXB) begin
        exp_err = 1;
        exp_code = 3;
      end else if (term == 1) begin
        exp_err = 1;
        exp_code = 1;
      end else if (len % 8 != 0) begin
        exp_err = 1;
        exp_code = 2;
      end else begin
        exp_done = 1;
      end
    end
  endtask

  task automatic run_packet(input int term, input string tag, input bit gaps, input int se0_len);
    int ob, bd, be, nv, ec;
    ob = obs_q.size();
    bd = n_done;
    be = n_err;
    bit_cyc.delete();
    model(term);
    for (int i = 0; i < st.size(); i++) begin
      send_bit(st[i], (gaps && $urandom_range(0, 3) == 0) ? 1 : 0);
      if (i == exp_m) check({tag, " active"}, {31'd0, bus.rx_active}, 32'd1);
    end
    if (term == 1) begin
      bus.stuff_err = 1'b1;
      stuff_cyc = cyc;
      tick();
      bus.stuff_err = 1'b0;
      repeat (3) send_bit(1'($urandom_range(0, 1)), 0);
    end
    bus.rx_se0       = 1'b1;
    se0_rise_cyc     = cyc;
    bus.rx_bit       = 1'($urandom_range(0, 1));
    bus.rx_bit_valid = gaps && ($urandom_range(0, 3) == 0);
    tick();
    bus.rx_bit_valid = 1'b0;
    repeat (se0_len - 1) tick();
    bus.rx_se0   = 1'b0;
    se0_fall_cyc = cyc;
    repeat (4) tick();

    nv = obs_q.size() - ob;
    check({tag, " nvalid"}, nv, exp_bytes.size());
    for (int i = 0; i < exp_bytes.size() && i < nv; i++)
      check($sformatf("%s byte%0d", tag, i), obs_q[ob+i], exp_bytes[i]);
    check({tag, " ndone"}, n_done - bd, exp_done);
    check({tag, " nerror"}, n_err - be, exp_err);
    if (exp_done != 0) check({tag, " done_time"}, done_cyc, se0_fall_cyc + 1);
    if (exp_err != 0) begin
      check({tag, " err_code"}, {30'd0, err_obs}, exp_code);
      case (exp_code)
        0:       ec = bit_cyc[31] + 1;
        3:       ec = bit_cyc[exp_m + 8*(MAXB+1)] + 1;
        1:       ec = stuff_cyc + 1;
        default: ec = se0_rise_cyc + 1;
      endcase
      check({tag, " err_time"}, err_cyc, ec);
    end
    check({tag, " err_hold"}, {30'd0, bus.rx_err_code}, exp_code);
    check({tag, " byte_cnt"}, {21'd0, bus.rx_byte_cnt}, exp_cnt);
    check({tag, " rx_data"}, {24'd0, bus.rx_data}, exp_last);
    check({tag, " idle_active"}, {31'd0, bus.rx_active}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within the time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    int ob, bd, be;
    int kind, nb, term;
    nRST             = 1'b0;
    bus.rx_enable    = 1'b1;
    bus.rx_bit       = 1'b0;
    bus.rx_bit_valid = 1'b0;
    bus.rx_se0       = 1'b0;
    bus.stuff_err    = 1'b0;
    repeat (3) tick();

    check("reset rx_data",  {24'd0, bus.rx_data}, 0);
    check("reset valid",    {31'd0, bus.rx_valid}, 0);
    check("reset active",   {31'd0, bus.rx_active}, 0);
    check("reset done",     {31'd0, bus.rx_done}, 0);
    check("reset error",    {31'd0, bus.rx_error}, 0);
    check("reset err_code", {30'd0, bus.rx_err_code}, 0);
    check("reset byte_cnt", {21'd0, bus.rx_byte_cnt}, 0);
    nRST = 1'b1;
    repeat (2) tick();

    st.delete(); push_sync(); push_byte(8'hC3); push_byte(8'hA5);
    run_packet(0, "t1_good", 1'b0, 2);

    st.delete(); push_sync(); push_byte(8'hC3);
    st.push_back(1'b1); st.push_back(1'b0); st.push_back(1'b1);
    run_packet(0, "t2_partial", 1'b0, 2);

    st.delete(); push_sync(); repeat (4) st.push_back(1'b1);
    run_packet(1, "t3_stuff", 1'b0, 2);
    st.delete(); push_sync(); push_byte(8'h5A);
    run_packet(0, "t3_after", 1'b0, 3);

    st.delete(); repeat (40) st.push_back(1'b1);
    run_packet(0, "t4_timeout", 1'b0, 2);

    st.delete(); push_sync();
    push_byte(8'h01); push_byte(8'h82); push_byte(8'h7E); push_byte(8'hF0); push_byte(8'h3C);
    run_packet(0, "t5_overflow", 1'b0, 2);

    // rx_enable dropped mid-byte
    st.delete(); push_sync(); push_byte(8'h11);
    st.push_back(1'b1); st.push_back(1'b0); st.push_back(1'b1);
    ob = obs_q.size(); bd = n_done; be = n_err;
    for (int i = 0; i < st.size(); i++) send_bit(st[i], 0);
    bus.rx_enable = 1'b0;
    tick();
    send_bit(1'b0, 0);
    send_bit(1'b1, 1);
    check("t6_en active", {31'd0, bus.rx_active}, 0);
    check("t6_en nvalid", obs_q.size() - ob, 1);
    check("t6_en pulses", (n_done - bd) + (n_err - be), 0);
    check("t6_en rx_data", {24'd0, bus.rx_data}, 8'h11);
    check("t6_en byte_cnt", {21'd0, bus.rx_byte_cnt}, 1);
    exp_last = 8'h11;
    exp_cnt = 1;
    bus.rx_enable = 1'b1;
    tick();
    st.delete(); push_sync(); push_byte(8'h96);
    run_packet(0, "t6_en_after", 1'b0, 2);

    // nRST asserted mid-packet
    st.delete(); push_sync(); push_byte(8'h77); st.push_back(1'b1); st.push_back(1'b1);
    ob = obs_q.size(); bd = n_done; be = n_err;
    for (int i = 0; i < st.size(); i++) send_bit(st[i], 0);
    nRST = 1'b0;
    #1;
    check("t6_rst rx_data", {24'd0, bus.rx_data}, 0);
    check("t6_rst byte_cnt", {21'd0, bus.rx_byte_cnt}, 0);
    check("t6_rst active", {31'd0, bus.rx_active}, 0);
    check("t6_rst err_code", {30'd0, bus.rx_err_code}, 0);
    repeat (2) tick();
    nRST = 1'b1;
    repeat (2) tick();
    check("t6_rst nvalid", obs_q.size() - ob, 1);
    check("t6_rst pulses", (n_done - bd) + (n_err - be), 0);
    exp_last = 8'h00;
    exp_cnt = 0;
    exp_code = 0;
    st.delete(); push_sync(); push_byte(8'hE1); push_byte(8'h2D);
    run_packet(0, "t6_rst_after", 1'b0, 2);

    for (int n = 0; n < 30; n++) begin
      st.delete();
      term = 0;
      kind = $urandom_range(0, 9);
      if (kind == 0) begin
        repeat ($urandom_range(5, 40)) st.push_back(1'($urandom_range(0, 1)));
      end else begin
        repeat ($urandom_range(0, 3)) st.push_back(1'($urandom_range(0, 1)));
        push_sync();
        nb = ($urandom_range(0, 4) == 0) ? $urandom_range(5, 6) : $urandom_range(0, 4);
        repeat (nb) push_byte(8'($urandom));
        if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 7)) st.push_back(1'($urandom_range(0, 1)));
        if (nb <= MAXB && $urandom_range(0, 4) == 0) term = 1;
      end
      run_packet(term, $sformatf("rnd%0d", n), 1'b1, $urandom_range(2, 3));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
